// File: rtl/spi_ram_pkg.sv
// Shared encodings for the SPI-to-RAM arbiter: command codes, FSM states, access owners.
package spi_ram_pkg;
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Owner value doubles as the requester index into req/gnt.
  localparam logic OWN_SPI = 1'b0;
  localparam logic OWN_LOC = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the requester that did not win last is granted.
module rr_arb2
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       rr_last
);
  logic r_last;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last == OWN_LOC) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= OWN_LOC;
    end else if (advance && (gnt != 2'b00)) begin
      r_last <= gnt[OWN_LOC];
    end
  end

  assign rr_last = r_last;
endmodule

// File: rtl/spi_ram_arbiter.sv
// Decodes SPI slave command words into RAM accesses and shares the single-port RAM
// with a local requester; SPI read data is returned on spi_tx_data/spi_tx_valid.
module spi_ram_arbiter
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AUTO_INC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        spi_rx_data,
  input  logic              spi_rx_valid,
  output logic [7:0]        spi_tx_data,
  output logic              spi_tx_valid,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_gnt,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              loc_rvalid,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              err_overrun,
  output logic              err_rd_noaddr
);
  logic [1:0]        r_state;
  logic              r_rx_vld_d;
  logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
  logic              r_rd_addr_ok;
  logic              r_pend_vld, r_pend_we;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_wdata;
  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [7:0]        r_tx_data;
  logic              r_tx_vld;
  logic [DATA_W-1:0] r_loc_rdata;
  logic              r_loc_rvalid;
  logic              r_err_ovr, r_err_noaddr;

  logic       w_edge, w_idle, w_q_wr, w_q_rd, w_queue, w_rr_last;
  logic [1:0] w_cmd, w_req, w_gnt;

  assign w_edge  = spi_rx_valid & ~r_rx_vld_d;
  assign w_cmd   = spi_rx_data[9:8];
  assign w_idle  = (r_state == ST_IDLE);
  assign w_q_wr  = w_edge & (w_cmd == CMD_WR_DATA);
  assign w_q_rd  = w_edge & (w_cmd == CMD_RD_DATA) & r_rd_addr_ok;
  assign w_queue = w_q_wr | w_q_rd;
  assign w_req   = {loc_req, r_pend_vld} & {2{w_idle & rst_n}};

  // After a grant rr_last names the winner, so it also identifies the owner in ACCESS/RESP.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (w_req),
    .advance (w_idle),
    .gnt     (w_gnt),
    .rr_last (w_rr_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_rx_vld_d   <= 1'b0;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_rd_addr_ok <= 1'b0;
      r_pend_vld   <= 1'b0;
      r_pend_we    <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_wdata <= '0;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_tx_data    <= '0;
      r_tx_vld     <= 1'b0;
      r_loc_rdata  <= '0;
      r_loc_rvalid <= 1'b0;
      r_err_ovr    <= 1'b0;
      r_err_noaddr <= 1'b0;
    end else begin
      r_rx_vld_d   <= spi_rx_valid;
      r_ram_en     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_loc_rvalid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_state  <= ST_ACCESS;
            r_ram_en <= 1'b1;
            if (w_gnt[OWN_LOC]) begin
              r_ram_we    <= loc_we;
              r_ram_addr  <= loc_addr;
              r_ram_wdata <= loc_wdata;
            end else begin
              r_ram_we    <= r_pend_we;
              r_ram_addr  <= r_pend_addr;
              r_ram_wdata <= r_pend_wdata;
            end
          end
        end
        ST_ACCESS: r_state <= r_ram_we ? ST_IDLE : ST_RESP;
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (w_rr_last == OWN_SPI) begin
            r_tx_data <= ram_rdata;
            r_tx_vld  <= 1'b1;
          end else begin
            r_loc_rdata  <= ram_rdata;
            r_loc_rvalid <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_gnt[OWN_SPI]) r_pend_vld <= 1'b0;
      if (w_queue) begin
        r_pend_vld   <= 1'b1;
        r_pend_we    <= w_q_wr;
        r_pend_addr  <= w_q_wr ? r_wr_addr : r_rd_addr;
        r_pend_wdata <= spi_rx_data[DATA_W-1:0];
        if (r_pend_vld && !w_gnt[OWN_SPI]) r_err_ovr <= 1'b1;
      end

      if (w_edge) begin
        r_tx_vld <= 1'b0;
        case (w_cmd)
          CMD_WR_ADDR: r_wr_addr <= spi_rx_data[ADDR_W-1:0];
          CMD_WR_DATA: if (AUTO_INC != 0) r_wr_addr <= r_wr_addr + ADDR_W'(1);
          CMD_RD_ADDR: begin
            r_rd_addr    <= spi_rx_data[ADDR_W-1:0];
            r_rd_addr_ok <= 1'b1;
          end
          CMD_RD_DATA: begin
            if (r_rd_addr_ok) begin
              r_rd_addr_ok <= 1'b0;
              if (AUTO_INC != 0) r_rd_addr <= r_rd_addr + ADDR_W'(1);
            end else begin
              r_err_noaddr <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign loc_gnt       = w_gnt[OWN_LOC];
  assign ram_en        = r_ram_en;
  assign ram_we        = r_ram_we;
  assign ram_addr      = r_ram_addr;
  assign ram_wdata     = r_ram_wdata;
  assign spi_tx_data   = r_tx_data;
  assign spi_tx_valid  = r_tx_vld;
  assign loc_rdata     = r_loc_rdata;
  assign loc_rvalid    = r_loc_rvalid;
  assign err_overrun   = r_err_ovr;
  assign err_rd_noaddr = r_err_noaddr;
endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench: a RAM model plus ordered scoreboards of expected RAM accesses and read returns.
module tb_spi_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       loc_req, loc_we;
  logic [7:0] loc_addr, loc_wdata;
  logic       loc_gnt;
  logic [7:0] loc_rdata;
  logic       loc_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata = 8'h00;
  logic       err_overrun, err_rd_noaddr;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_W(8), .DATA_W(8), .AUTO_INC(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .err_overrun(err_overrun), .err_rd_noaddr(err_rd_noaddr)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } acc_t;

  acc_t       exp_acc[$];
  logic [7:0] exp_lrd[$];
  logic [7:0] exp_tx[$];
  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;
  int n_ram_en = 0;
  int n_lrv    = 0;
  logic prev_tx = 1'b0;
  logic prev_en = 1'b0;
  acc_t cur;

  logic [38:0] all_outs;
  assign all_outs = {spi_tx_data, spi_tx_valid, loc_gnt, loc_rdata, loc_rvalid, ram_en,
                     ram_we, ram_addr, ram_wdata, err_overrun, err_rd_noaddr};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Single-port RAM with one-cycle read latency; a few locations carry known contents.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[8'h40] <= 8'h5C;
      mem[8'h10] <= 8'h3C;
      mem[8'h20] <= 8'h2D;
    end
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  always @(negedge clk) begin
    if (ram_en) begin
      n_ram_en++;
      check("ram_en_one_cycle", prev_en, 1'b0);
      check("ram_access_expected", exp_acc.size() != 0, 1'b1);
      if (exp_acc.size() != 0) begin
        cur = exp_acc.pop_front();
        check("ram_we", ram_we, cur.we);
        check("ram_addr", ram_addr, cur.addr);
        if (cur.we) check("ram_wdata", ram_wdata, cur.wdata);
      end
    end
    if (loc_rvalid) begin
      n_lrv++;
      check("loc_rvalid_expected", exp_lrd.size() != 0, 1'b1);
      if (exp_lrd.size() != 0) check("loc_rdata", loc_rdata, exp_lrd.pop_front());
    end
    if (spi_tx_valid && !prev_tx) begin
      check("tx_valid_expected", exp_tx.size() != 0, 1'b1);
      if (exp_tx.size() != 0) check("spi_tx_data", spi_tx_data, exp_tx.pop_front());
    end
    prev_tx = spi_tx_valid;
    prev_en = ram_en;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_cmd(input logic [1:0] cmd, input logic [7:0] pay);
    spi_rx_data  = {cmd, pay};
    spi_rx_valid = 1'b1;
    tick(1);
    spi_rx_valid = 1'b0;
    tick(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && (exp_acc.size() + exp_lrd.size() + exp_tx.size()) != 0; i++)
      tick(1);
    check({"drain_", nm}, exp_acc.size() + exp_lrd.size() + exp_tx.size(), 0);
    tick(2);
  endtask

  task automatic wait_negedges(input logic want_gnt, output int n);
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((want_gnt && loc_gnt) || (!want_gnt && loc_rvalid)) begin
        n = i;
        break;
      end
    end
  endtask

  int base, cyc;

  initial begin
    rst_n = 1'b0; spi_rx_data = '0; spi_rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h40; loc_wdata = 8'h00;
    tick(2);
    @(negedge clk);
    check("reset_outputs_zero", all_outs, 39'd0);
    @(posedge clk); #1;
    loc_req = 1'b0;
    rst_n   = 1'b1;

    // SPI write: address then data; ram_en two cycles after the command edge.
    spi_cmd(2'b00, 8'h25);
    exp_acc.push_back('{we: 1'b1, addr: 8'h25, wdata: 8'hA5});
    spi_rx_data = 10'h1A5; spi_rx_valid = 1'b1;
    @(negedge clk); check("wr_lat_c0", ram_en, 1'b0);
    @(posedge clk); #1; spi_rx_valid = 1'b0;
    @(negedge clk); check("wr_lat_c1", ram_en, 1'b0);
    @(negedge clk); check("wr_lat_c2", {ram_en, ram_we, ram_addr, ram_wdata}, {2'b11, 8'h25, 8'hA5});
    drain("spi_write");
    check("wr_no_tx_valid", spi_tx_valid, 1'b0);

    // SPI read of the location just written.
    spi_cmd(2'b10, 8'h25);
    exp_acc.push_back('{we: 1'b0, addr: 8'h25, wdata: 8'h00});
    exp_tx.push_back(8'hA5);
    spi_cmd(2'b11, 8'h00);
    tick(3);
    check("rd_tx", {spi_tx_valid, spi_tx_data}, {1'b1, 8'hA5});
    tick(5);
    check("rd_tx_held", {spi_tx_valid, spi_tx_data}, {1'b1, 8'hA5});
    spi_cmd(2'b00, 8'h25);
    check("rd_tx_drop_on_cmd", spi_tx_valid, 1'b0);
    drain("spi_read");

    // Level held for 20 cycles is one command.
    base = n_ram_en;
    exp_acc.push_back('{we: 1'b1, addr: 8'h25, wdata: 8'h11});
    spi_rx_data = 10'h111; spi_rx_valid = 1'b1;
    tick(20);
    spi_rx_valid = 1'b0;
    tick(5);
    check("held_valid_one_write", n_ram_en - base, 1);
    drain("held_valid");

    // Tie straight after reset: SPI first, then the local read.
    do_reset();
    exp_acc.push_back('{we: 1'b1, addr: 8'h00, wdata: 8'h77});
    exp_acc.push_back('{we: 1'b0, addr: 8'h40, wdata: 8'h00});
    exp_lrd.push_back(8'h5C);
    spi_rx_data = 10'h177; spi_rx_valid = 1'b1;
    tick(1);
    spi_rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h40; loc_wdata = 8'h00;
    wait_negedges(1'b1, cyc);
    check("tie1_loc_gnt_cycle", cyc, 3);
    @(posedge clk); #1; loc_req = 1'b0;
    wait_negedges(1'b0, cyc);
    check("loc_rvalid_after_gnt", cyc, 3);
    drain("tie1");

    // A lone SPI grant leaves SPI as last winner, so the following tie goes to local.
    exp_acc.push_back('{we: 1'b1, addr: 8'h00, wdata: 8'h88});
    spi_cmd(2'b01, 8'h88);
    drain("solo_spi");
    exp_acc.push_back('{we: 1'b1, addr: 8'h41, wdata: 8'h66});
    exp_acc.push_back('{we: 1'b1, addr: 8'h00, wdata: 8'h99});
    spi_rx_data = 10'h199; spi_rx_valid = 1'b1;
    tick(1);
    spi_rx_valid = 1'b0;
    loc_req = 1'b1; loc_we = 1'b1; loc_addr = 8'h41; loc_wdata = 8'h66;
    wait_negedges(1'b1, cyc);
    check("tie2_loc_gnt_cycle", cyc, 1);
    @(posedge clk); #1; loc_req = 1'b0;
    drain("tie2");

    // Read-data without a read address, then an overrun behind a local read.
    do_reset();
    base = n_ram_en;
    spi_cmd(2'b11, 8'h00);
    tick(4);
    check("noaddr_flags", {err_rd_noaddr, err_overrun}, 2'b10);
    check("noaddr_no_access", n_ram_en - base, 0);
    exp_acc.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    exp_acc.push_back('{we: 1'b1, addr: 8'h00, wdata: 8'hBB});
    exp_lrd.push_back(8'h3C);
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h10;
    spi_rx_data = 10'h1AA; spi_rx_valid = 1'b1;
    @(negedge clk); check("ovr_loc_gnt", loc_gnt, 1'b1);
    @(posedge clk); #1; loc_req = 1'b0; spi_rx_valid = 1'b0;
    tick(1);
    spi_rx_data = 10'h1BB; spi_rx_valid = 1'b1;
    tick(1);
    spi_rx_valid = 1'b0;
    drain("overrun");
    check("overrun_flag", err_overrun, 1'b1);

    // Reset during the RAM cycle of a local read abandons it.
    do_reset();
    base = n_lrv;
    exp_acc.push_back('{we: 1'b0, addr: 8'h20, wdata: 8'h00});
    loc_req = 1'b1; loc_we = 1'b0; loc_addr = 8'h20;
    @(negedge clk); check("rst_loc_gnt", loc_gnt, 1'b1);
    @(posedge clk); #1; rst_n = 1'b0; loc_req = 1'b0;
    @(negedge clk); check("rst_access_cycle", ram_en, 1'b1);
    @(negedge clk); check("rst_outputs_zero", all_outs, 39'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick(6);
    check("rst_no_loc_rvalid", n_lrv - base, 0);
    exp_acc.push_back('{we: 1'b1, addr: 8'h00, wdata: 8'h5A});
    spi_cmd(2'b01, 8'h5A);
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
